uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each stored word (matches receiver dout).
REQ-002 SHALL have parameter ADDR_W, default 4, log2 of depth (depth = 2**ADDR_W = 16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low; sampled on rising clk.
REQ-005 SHALL have port wr  input  1  write strobe, one-cycle pulse; driven by receiver rx_done_tick.
REQ-006 SHALL have port w_data  input  DATA_W  write data; driven by receiver dout.
REQ-007 SHALL have port rd  input  1  read/pop strobe from consumer.
REQ-008 SHALL have port r_data  output  DATA_W  head-of-queue word, first-word-fall-through.
REQ-009 SHALL have port empty  output  1  high when count == 0.
REQ-010 SHALL have port full  output  1  high when count == 2**ADDR_W.
REQ-011 SHALL have port count  output  ADDR_W+1  number of stored words, 0..2**ADDR_W.
REQ-012 SHALL have port overflow  output  1  sticky flag, write attempted while full.
REQ-013 SHALL have port clr_ovf  input  1  clears overflow.

Function
REQ-014 SHALL hold words in storage of 2**ADDR_W entries with write pointer w_ptr and read pointer r_ptr, each ADDR_W bits, wrapping modulo 2**ADDR_W (15 -> 0).
REQ-015 SHALL present r_data = storage[r_ptr] combinationally; r_data valid only while empty == 0; no read latency.
REQ-016 SHALL, on wr=1 and full=0, store w_data at w_ptr and increment w_ptr; word visible on r_data/count from next cycle.
REQ-017 SHALL, on rd=1 and empty=0, increment r_ptr; next word appears on r_data next cycle.
REQ-018 SHALL ignore rd while empty (no pointer/count change, no underflow flag).
REQ-019 SHALL, on wr=1 while full and rd=0, drop w_data, leave pointers/count unchanged, set overflow=1 next cycle.
REQ-020 SHALL, on wr=1 and rd=1 while full, perform both; count stays 2**ADDR_W, overflow unaffected.
REQ-021 SHALL, on wr=1 and rd=1 while empty, perform write only; count becomes 1.
REQ-022 SHALL, on wr=1 and rd=1 otherwise (0<count<full), perform both; count unchanged.
REQ-023 SHALL update count: +1 write only, -1 read only, unchanged on both/neither; count never exceeds 2**ADDR_W or goes below 0.
REQ-024 SHALL derive empty and full from registered count, never both high.
REQ-025 SHALL keep overflow high until clr_ovf=1; clr_ovf and new overflow event in same cycle leave overflow=1 (set wins).
REQ-026 SHALL tolerate back-to-back wr on consecutive cycles (no minimum gap).

Reset
REQ-027 SHALL, when rst=0 at rising clk, set w_ptr=0, r_ptr=0, count=0, empty=1, full=0, overflow=0.
REQ-028 SHALL not reset storage contents; r_data is don't-care while empty.
REQ-029 SHALL, on reset mid-operation, discard all stored words; wr/rd in the reset cycle are ignored.
REQ-030 SHALL resume normal operation on the first rising clk with rst=1.

Verification
REQ-031 Bench SHALL cover: reset, write 0xA5 -> next cycle empty=0, count=1, r_data=0xA5; rd -> next cycle empty=1, count=0.
REQ-032 Bench SHALL cover: write 0x00..0x0F (16 words) -> full=1, count=16; pop all 16 -> values 0x00..0x0F in order, then empty=1.
REQ-033 Bench SHALL cover: full, wr 0xEE with rd=0 -> overflow=1, count=16, 0xEE never read; clr_ovf -> overflow=0.
REQ-034 Bench SHALL cover: full, simultaneous wr 0x55 and rd -> count=16, overflow=0, 0x55 read last after 15 other words.
REQ-035 Bench SHALL cover: empty, simultaneous wr 0x3C and rd -> count=1, r_data=0x3C; rd while empty -> no change.
REQ-036 Bench SHALL cover: pointer wrap (write 10, read 10, write 10, read 10) with data order intact; and rst=0 at count=5 -> count=0, empty=1, overflow=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive queue sitting behind a UART
// receiver. Holds 2**ADDR_W words, reports occupancy, and keeps a sticky
// overflow flag for bytes dropped while the queue was full.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] w_ptr, r_ptr;
  logic              do_wr, do_rd;

  // Flags come straight from the registered count, so they can never both be high.
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign r_data = mem[r_ptr];

  // A write while full still lands when a pop frees the head slot in the same
  // cycle; a pop while empty is ignored, so wr+rd on empty is a plain write.
  assign do_wr = wr & (~full | rd);
  assign do_rd = rd & ~empty;

  // Storage is not reset; gating on rst keeps the reset cycle's write inert.
  always_ff @(posedge clk) begin
    if (rst && do_wr) mem[w_ptr] <= w_data;
  end

  // Pointers and occupancy; pointers wrap naturally at ADDR_W bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (do_wr) w_ptr <= w_ptr + 1'b1;
      if (do_rd) r_ptr <= r_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a dropped write sets it, and setting beats clearing.
  always_ff @(posedge clk) begin
    if (!rst)                  overflow <= 1'b0;
    else if (wr & full & ~rd)  overflow <= 1'b1;
    else if (clr_ovf)          overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: inputs change on the falling edge, outputs
// are checked on the following falling edge, one clock after the rising edge.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0, rd = 1'b0, clr_ovf = 1'b0;
  logic [7:0] w_data = '0;
  logic [7:0] r_data;
  logic       empty, full, overflow;
  logic [4:0] count;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // One clock: apply inputs now (at a falling edge), return at the next falling edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr = w; w_data = d; rd = r; clr_ovf = c;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int c, input logic e, input logic f, input logic o);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"},  32'(full),  32'(f));
    chk({tag, ".ovf"},   32'(overflow), 32'(o));
  endtask

  // Check head word then pop it.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(r_data), 32'(exp));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    // Reset
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk_state("reset", 0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;

    // Single write / read
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk_state("wr_a5", 1, 1'b0, 1'b0, 1'b0);
    chk("wr_a5.rdata", 32'(r_data), 32'h A5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("rd_a5", 0, 1'b1, 1'b0, 1'b0);

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk_state("fill16", 16, 1'b0, 1'b1, 1'b0);

    // Overflow while full, then clear; then set-wins-over-clear
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk_state("ovf_set", 16, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk_state("ovf_clr", 16, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    chk_state("ovf_setwins", 16, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2", 32'(overflow), 32'h0);

    // Drain: 0x00..0x0F in order, 0xEE never appears
    for (int i = 0; i < 16; i++) pop_chk($sformatf("drain[%0d]", i), 8'(i));
    chk_state("drained", 0, 1'b1, 1'b0, 1'b0);

    // Full with simultaneous wr+rd
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk_state("full_wrrd", 16, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) pop_chk($sformatf("fwr[%0d]", i), 8'(8'h10 + i));
    pop_chk("fwr.last55", 8'h55);
    chk_state("fwr_drained", 0, 1'b1, 1'b0, 1'b0);

    // Empty with simultaneous wr+rd: write only
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    chk_state("empty_wrrd", 1, 1'b0, 1'b0, 1'b0);
    chk("empty_wrrd.rdata", 32'(r_data), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("rd_empty", 0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_underrd.rdata", 32'(r_data), 32'h77);
    chk("post_underrd.count", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap: 10 in / 10 out twice
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h80 + 16*pass + i), 1'b0, 1'b0);
      chk($sformatf("wrap%0d.count", pass), 32'(count), 32'd10);
      for (int i = 0; i < 10; i++)
        pop_chk($sformatf("wrap%0d[%0d]", pass, i), 8'(8'h80 + 16*pass + i));
      chk($sformatf("wrap%0d.empty", pass), 32'(empty), 32'd1);
    end

    // Mid-operation reset at count=5 with overflow set; wr in reset cycle ignored
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("pre_rst", 5, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    chk_state("mid_rst", 0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 8'h42, 1'b0, 1'b0);
    chk_state("post_rst", 1, 1'b0, 1'b0, 1'b0);
    chk("post_rst.rdata", 32'(r_data), 32'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
